// File: rtl/qam_mapper_pkg.sv
// Shared types, level defaults and helpers for the streaming constellation mapper.
// QAM_MAPPER_256_EN widens mode to 3 bits and adds the 256QAM mode.
package qam_mapper_pkg;

`ifdef QAM_MAPPER_256_EN
  localparam int MODE_W = 3;
  localparam int SYM_W  = 8;
`else
  localparam int MODE_W = 2;
  localparam int SYM_W  = 6;
`endif
  localparam int CODE_W = SYM_W / 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BPSK  = 0,
    MODE_QPSK  = 1,
    MODE_16QAM = 2,
    MODE_64QAM = 3
`ifdef QAM_MAPPER_256_EN
    , MODE_256QAM = 4
`endif
  } mode_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int DEF_BPSK_L    = 1470;
  localparam int DEF_QPSK_L    = 1040;
  localparam int DEF_Q16_L0    = 465;
  localparam int DEF_Q16_L1    = 1395;
  localparam int DEF_Q64_L0    = 210;
  localparam int DEF_Q64_L1    = 630;
  localparam int DEF_Q64_L2    = 1050;
  localparam int DEF_Q64_L3    = 1470;
  localparam int DEF_Q256_L0   = 105;
  localparam int DEF_Q256_STEP = 210;

  function automatic int bps_of(mode_t m);
    case (m)
      MODE_BPSK:   return 1;
      MODE_QPSK:   return 2;
      MODE_16QAM:  return 4;
      MODE_64QAM:  return 6;
`ifdef QAM_MAPPER_256_EN
      MODE_256QAM: return 8;
`endif
      default:     return 1;
    endcase
  endfunction

  function automatic logic [2:0] gray2bin3(logic [2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  function automatic int buf_width(int data_w);
`ifdef QAM_MAPPER_256_EN
    return (2 * data_w > 16) ? 2 * data_w : 16;
`else
    return 2 * data_w;
`endif
  endfunction

endpackage

// File: rtl/qam_level_lut.sv
// Combinational per-axis level map: (mode, Gray axis code) -> two's complement level.
// QAM_MAPPER_256_EN adds the 4-bit/axis 256QAM map.
module qam_level_lut
  import qam_mapper_pkg::*;
#(
  parameter int FFT_DEPTH = 12,
  parameter int BPSK_L    = DEF_BPSK_L,
  parameter int QPSK_L    = DEF_QPSK_L,
  parameter int Q16_L0    = DEF_Q16_L0,
  parameter int Q16_L1    = DEF_Q16_L1,
  parameter int Q64_L0    = DEF_Q64_L0,
  parameter int Q64_L1    = DEF_Q64_L1,
  parameter int Q64_L2    = DEF_Q64_L2,
  parameter int Q64_L3    = DEF_Q64_L3
`ifdef QAM_MAPPER_256_EN
  , parameter int Q256_L0   = DEF_Q256_L0
  , parameter int Q256_STEP = DEF_Q256_STEP
`endif
) (
  input  mode_t                 mode,
  input  logic [CODE_W-1:0]     code,
  output logic [FFT_DEPTH-1:0]  level
);

  logic neg;
  int   mag;
  int   val;

  // The code MSB is the sign; the remaining bits pick the magnitude in Gray order.
  always_comb begin
    neg = 1'b0;
    mag = 0;
    case (mode)
      MODE_BPSK: begin
        neg = !code[0];
        mag = BPSK_L;
      end
      MODE_QPSK: begin
        neg = !code[0];
        mag = QPSK_L;
      end
      MODE_16QAM: begin
        neg = !code[1];
        mag = code[0] ? Q16_L0 : Q16_L1;
      end
      MODE_64QAM: begin
        neg = !code[2];
        case (code[1:0])
          2'd0:    mag = Q64_L3;
          2'd1:    mag = Q64_L2;
          2'd2:    mag = Q64_L0;
          default: mag = Q64_L1;
        endcase
      end
`ifdef QAM_MAPPER_256_EN
      MODE_256QAM: begin
        neg = !code[3];
        mag = Q256_L0 + Q256_STEP * (7 - int'(gray2bin3(code[2:0])));
      end
`endif
      default: ;
    endcase
    val   = neg ? -mag : mag;
    level = val[FFT_DEPTH-1:0];
  end

endmodule

// File: rtl/qam_mapper_stream.sv
// Streaming constellation mapper: word gearbox into bps-bit symbols, I/Q level mapping, output register.
// QAM_MAPPER_256_EN enables the 256QAM mode (3-bit mode port, buffer of at least 16 bits).
module qam_mapper_stream
  import qam_mapper_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FFT_DEPTH = 12,
  parameter int BPSK_L    = DEF_BPSK_L,
  parameter int QPSK_L    = DEF_QPSK_L,
  parameter int Q16_L0    = DEF_Q16_L0,
  parameter int Q16_L1    = DEF_Q16_L1,
  parameter int Q64_L0    = DEF_Q64_L0,
  parameter int Q64_L1    = DEF_Q64_L1,
  parameter int Q64_L2    = DEF_Q64_L2,
  parameter int Q64_L3    = DEF_Q64_L3
`ifdef QAM_MAPPER_256_EN
  , parameter int Q256_L0   = DEF_Q256_L0
  , parameter int Q256_STEP = DEF_Q256_STEP
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MODE_W-1:0]     mode,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [FFT_DEPTH-1:0]  sub_i,
  output logic [FFT_DEPTH-1:0]  sub_q,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output state_t                dbg_state
);

  localparam int BUF_W  = buf_width(DATA_W);
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam logic [FILL_W-1:0] DATA_FILL = FILL_W'(DATA_W);

  // Handshake: a beat moves on a channel in every cycle where its valid and ready are both high
  // at the rising clock edge; out_valid and its payload never change while stalled.

  state_t                state_q, state_d;
  mode_t                 mode_q, mode_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [FFT_DEPTH-1:0]  sub_i_q, sub_i_d;
  logic [FFT_DEPTH-1:0]  sub_q_q, sub_q_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;

  logic [SYM_W-1:0]      sym;
  logic [CODE_W-1:0]     code_i, code_q;
  logic [FFT_DEPTH-1:0]  lvl_i, lvl_q;
  logic [FILL_W-1:0]     bps_fill, pop_n, fill_after;
  logic                  can_load, start_ok, restart, full_pop, pad_pop, accept, last_sym;

  always_comb begin
    sym    = buf_q[SYM_W-1:0];
    code_i = '0;
    code_q = '0;
    case (mode_q)
      MODE_BPSK:  code_i[0] = sym[0];
      MODE_QPSK: begin
        code_i[0] = sym[0];
        code_q[0] = sym[1];
      end
      MODE_16QAM: begin
        code_i[1:0] = sym[1:0];
        code_q[1:0] = sym[3:2];
      end
      MODE_64QAM: begin
        code_i[2:0] = sym[2:0];
        code_q[2:0] = sym[5:3];
      end
`ifdef QAM_MAPPER_256_EN
      MODE_256QAM: begin
        code_i = sym[3:0];
        code_q = sym[7:4];
      end
`endif
      default: ;
    endcase
  end

  qam_level_lut #(
    .FFT_DEPTH(FFT_DEPTH), .BPSK_L(BPSK_L), .QPSK_L(QPSK_L), .Q16_L0(Q16_L0), .Q16_L1(Q16_L1),
    .Q64_L0(Q64_L0), .Q64_L1(Q64_L1), .Q64_L2(Q64_L2), .Q64_L3(Q64_L3)
`ifdef QAM_MAPPER_256_EN
    , .Q256_L0(Q256_L0), .Q256_STEP(Q256_STEP)
`endif
  ) u_lut_i (.mode(mode_q), .code(code_i), .level(lvl_i));

  qam_level_lut #(
    .FFT_DEPTH(FFT_DEPTH), .BPSK_L(BPSK_L), .QPSK_L(QPSK_L), .Q16_L0(Q16_L0), .Q16_L1(Q16_L1),
    .Q64_L0(Q64_L0), .Q64_L1(Q64_L1), .Q64_L2(Q64_L2), .Q64_L3(Q64_L3)
`ifdef QAM_MAPPER_256_EN
    , .Q256_L0(Q256_L0), .Q256_STEP(Q256_STEP)
`endif
  ) u_lut_q (.mode(mode_q), .code(code_q), .level(lvl_q));

  assign in_ready  = (state_q == RUN) && (fill_q <= DATA_FILL);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign sub_i     = sub_i_q;
  assign sub_q     = sub_q_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  always_comb begin
    bps_fill   = FILL_W'(bps_of(mode_q));
    can_load   = !out_valid_q || out_ready;
    restart    = start && (state_q != IDLE);
    // An idle start is dropped while the final symbol of the previous frame is still stalled.
    start_ok   = restart || (start && can_load);
    full_pop   = !restart && (state_q != IDLE) && (fill_q >= bps_fill) && can_load;
    pad_pop    = !restart && (state_q == DRAIN) && (fill_q != '0) && (fill_q < bps_fill) && can_load;
    accept     = (state_q == RUN) && !start && in_valid && in_ready;
    pop_n      = full_pop ? bps_fill : '0;
    fill_after = fill_q - pop_n;
    last_sym   = (state_q == DRAIN) && (pad_pop || (full_pop && (fill_after == '0)));

    state_d     = state_q;
    mode_d      = mode_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    sub_i_d     = sub_i_q;
    sub_q_d     = sub_q_q;
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_last_q && !out_ready;

    if (start_ok) begin
      state_d = RUN;
      mode_d  = mode_t'(mode);
      buf_d   = '0;
      fill_d  = '0;
      if (restart) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else begin
      if (full_pop || pad_pop) begin
        sub_i_d     = lvl_i;
        sub_q_d     = (mode_q == MODE_BPSK) ? '0 : lvl_q;
        out_valid_d = 1'b1;
        out_last_d  = last_sym;
        if (last_sym) state_d = IDLE;
      end
      // Bits above the fill level are kept zero, which also provides the final-symbol padding.
      buf_d  = pad_pop ? '0 : (buf_q >> pop_n);
      fill_d = pad_pop ? '0 : fill_after;
      if (accept) begin
        buf_d  = buf_d | (BUF_W'(in_data) << fill_after);
        fill_d = fill_after + DATA_FILL;
        if (in_last) state_d = DRAIN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_BPSK;
      buf_q       <= '0;
      fill_q      <= '0;
      sub_i_q     <= '0;
      sub_q_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      sub_i_q     <= sub_i_d;
      sub_q_q     <= sub_q_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_qam_mapper_stream.sv
// Bench for qam_mapper_stream: vector table, hand-written corner sequences and random frames
// scored against a bit-queue reference model.
module tb_qam_mapper_stream;
  import qam_mapper_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [MODE_W-1:0] mode = '0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [11:0]       sub_i, sub_q;
  logic              out_valid, out_last;
  logic              out_ready = 1'b0;
  logic              busy;
  state_t            dbg_state;

  qam_mapper_stream dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .sub_i(sub_i), .sub_q(sub_q), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / ready control ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  bit sb_en = 1'b1;

  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];
  int          obs_t[$];
  logic [7:0]  frame_q[$];
  int          t256[16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int lvl(input int m, input int c);
    int t16[4];
    int t64[8];
    t16 = '{-1395, -465, 1395, 465};
    t64 = '{-1470, -1050, -210, -630, 1470, 1050, 210, 630};
    case (m)
      0: return c[0] ? 1470 : -1470;
      1: return c[0] ? 1040 : -1040;
      2: return t16[c & 3];
      3: return t64[c & 7];
      4: return t256[c & 15];
      default: return 0;
    endcase
  endfunction

  task automatic model_frame(input int m);
    bit bits[$];
    int bps_tab[5];
    int n, h, sym, iv, qv;
    logic [11:0] i12, q12;
    bit lst;
    bps_tab = '{1, 2, 4, 6, 8};
    foreach (frame_q[w]) for (int b = 0; b < 8; b++) bits.push_back(frame_q[w][b]);
    n = bps_tab[m];
    while (bits.size() > 0) begin
      sym = 0;
      for (int k = 0; k < n; k++) if (bits.size() > 0) sym |= int'(bits.pop_front()) << k;
      lst = (bits.size() == 0);
      if (m == 0) begin
        iv = lvl(0, sym & 1);
        qv = 0;
      end else begin
        h  = n / 2;
        iv = lvl(m, sym & ((1 << h) - 1));
        qv = lvl(m, sym >> h);
      end
      i12 = iv[11:0];
      q12 = qv[11:0];
      exp_q.push_back({lst, i12, q12});
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got %0h want none", {out_last, sub_i, sub_q});
        end else begin
          check("sb_symbol", {out_last, sub_i, sub_q}, exp_q[0]);
        end
      end
      if (out_ready) begin
        obs_q.push_back({out_last, sub_i, sub_q});
        obs_t.push_back(cyc);
        if (sb_en && exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int m);
    mode  = MODE_W'(m);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input logic lst);
    int g = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = lst;
    do begin
      @(negedge clk);
      g++;
    end while (!in_ready && g < 500);
    check("in_accept_timeout", g >= 500, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(exp_q.size() == 0 && !busy && !out_valid) && g < 3000);
    check({name, "_timeout"}, g >= 3000, 0);
    @(posedge clk); #1;
  endtask

  task automatic set_ready(input int rm);
    ready_mode = rm;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic new_frame();
    exp_q.delete();
    obs_q.delete();
    obs_t.delete();
    frame_q.delete();
  endtask

  typedef struct {
    int          m;
    logic [7:0]  w;
    logic [11:0] i;
    logic [11:0] q;
  } vec_t;
  vec_t vecs[8];

  // ---------------- main sequence ----------------
  initial begin
    int nw, m, max_mode;
    for (int k = 0; k < 8; k++) begin
      int g;
      g = k ^ (k >> 1);
      t256[8 + g] = 105 + 210 * (7 - k);
      t256[g]     = -(105 + 210 * (7 - k));
    end

    vecs[0] = '{0, 8'h01, 12'h5BE, 12'h000};
    vecs[1] = '{0, 8'h00, 12'hA42, 12'h000};
    vecs[2] = '{1, 8'h93, 12'h410, 12'h410};
    vecs[3] = '{1, 8'h00, 12'hBF0, 12'hBF0};
    vecs[4] = '{2, 8'h02, 12'h573, 12'hA8D};
    vecs[5] = '{2, 8'h0D, 12'hE2F, 12'h1D1};
    vecs[6] = '{3, 8'h00, 12'hA42, 12'hA42};
    vecs[7] = '{3, 8'h3E, 12'h0D2, 12'h276};

    // Reset state
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_sub", {sub_i, sub_q}, 0);
    check("rst_state", dbg_state, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    set_ready(1);

    // Single-word frames: first symbol of each mode
    for (int v = 0; v < 8; v++) begin
      new_frame();
      frame_q.push_back(vecs[v].w);
      model_frame(vecs[v].m);
      do_start(vecs[v].m);
      send_word(vecs[v].w, 1'b1);
      wait_idle("vec");
      check("vec_nonempty", obs_q.size() != 0, 1);
      if (obs_q.size() != 0) check("vec_first_iq", obs_q[0][23:0], {vecs[v].i, vecs[v].q});
    end

    // 64QAM two-word frame with padded final symbol
    new_frame();
    frame_q = '{8'h00, 8'hFF};
    model_frame(3);
    do_start(3);
    send_word(8'h00, 1'b0);
    send_word(8'hFF, 1'b1);
    wait_idle("q64");
    check("q64_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("q64_sym0", obs_q[0], {1'b0, 12'hA42, 12'hA42});
      check("q64_sym1", obs_q[1], {1'b0, 12'h5BE, 12'h276});
      check("q64_pad", obs_q[2], {1'b1, 12'h276, 12'hBE6});
    end

    // QPSK one symbol per clock
    new_frame();
    frame_q = '{8'h93};
    model_frame(1);
    do_start(1);
    send_word(8'h93, 1'b1);
    wait_idle("qpsk");
    check("qpsk_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check("qpsk_s1", obs_q[1][23:0], {12'hBF0, 12'hBF0});
      check("qpsk_s2", obs_q[2][23:0], {12'h410, 12'hBF0});
      check("qpsk_s3", obs_q[3], {1'b1, 12'hBF0, 12'h410});
      check("qpsk_rate", obs_t[3] - obs_t[0], 3);
    end

    // Backpressure: stalled output holds, in_ready drops while fill exceeds one word
    set_ready(0);
    new_frame();
    frame_q = '{8'h93, 8'h5A, 8'hC3};
    model_frame(1);
    do_start(1);
    send_word(8'h93, 1'b0);
    send_word(8'h5A, 1'b0);
    in_data  = 8'hC3;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", {out_valid, sub_i, sub_q}, {1'b1, 12'h410, 12'h410});
    end
    @(posedge clk); #1;
    ready_mode = 1;
    begin
      int g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!in_ready && g < 100);
      check("bp_resume_timeout", g >= 100, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_idle("bp");
    check("bp_count", obs_q.size(), 12);

    // Restart during DRAIN drops the pending symbol and switches to BPSK
    set_ready(0);
    sb_en = 1'b0;
    new_frame();
    do_start(3);
    send_word(8'hFF, 1'b1);
    @(posedge clk); #1;
    check("drain_pending", out_valid, 1);
    check("drain_state", dbg_state, DRAIN);
    mode  = MODE_W'(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_drop", out_valid, 0);
    check("restart_state", dbg_state, RUN);
    new_frame();
    frame_q = '{8'h05};
    model_frame(0);
    sb_en = 1'b1;
    ready_mode = 1;
    send_word(8'h05, 1'b1);
    wait_idle("restart");
    check("restart_count", obs_q.size(), 8);
    if (obs_q.size() == 8) begin
      check("restart_s0", obs_q[0], {1'b0, 12'h5BE, 12'h000});
      check("restart_s1", obs_q[1], {1'b0, 12'hA42, 12'h000});
    end

    // Random frames against the model
`ifdef QAM_MAPPER_256_EN
    max_mode = 4;
`else
    max_mode = 3;
`endif
    set_ready(2);
    for (int f = 0; f < 24; f++) begin
      new_frame();
      m  = $urandom_range(0, max_mode);
      nw = $urandom_range(1, 5);
      for (int w = 0; w < nw; w++) frame_q.push_back(8'($urandom_range(0, 255)));
      model_frame(m);
      do_start(m);
      for (int w = 0; w < nw; w++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send_word(frame_q[w], w == nw - 1);
      end
      wait_idle("rand");
    end
    set_ready(1);

`ifdef QAM_MAPPER_256_EN
    new_frame();
    frame_q = '{8'h00};
    model_frame(4);
    do_start(4);
    send_word(8'h00, 1'b1);
    wait_idle("q256");
    check("q256_count", obs_q.size(), 1);
    if (obs_q.size() == 1) check("q256_sym", obs_q[0], {1'b1, 12'h9D9, 12'h9D9});
`endif

    // Asynchronous reset in the middle of a frame
    set_ready(0);
    sb_en = 1'b0;
    new_frame();
    do_start(1);
    send_word(8'h00, 1'b0);
    @(posedge clk); #1;
    check("mid_valid", out_valid, 1);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_sub", {sub_i, sub_q}, 0);
    check("arst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
